fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side drain engine for the team's `synchronous_fifo`. It watches the FIFO's `empty` flag, issues `r_en` strobes, and captures the FIFO's registered `data_out` into a 2-entry output buffer. Words are presented in FIFO order on a valid/ready stream, sustaining one word per cycle with full backpressure. It never under-reads the FIFO and counts every accepted transfer.

## Interface
- `DATA_WIDTH`, default 8: word width; must match the FIFO's `DATA_WIDTH`.
- `CNT_WIDTH`, default 16: width of the transfer counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `en`  in  1: fetch enable. While low, no new `fifo_r_en` is issued; words already in flight or buffered are still delivered.
- `fifo_empty`  in  1: FIFO `empty` flag.
- `fifo_data_out`  in  DATA_WIDTH: FIFO `data_out`, registered one cycle after `r_en`.
- `fifo_r_en`  out  1: FIFO read strobe.
- `m_valid`  out  1: output word valid.
- `m_ready`  in  1: downstream accept.
- `m_data`  out  DATA_WIDTH: output word.
- `rd_count`  out  CNT_WIDTH: number of accepted transfers (`m_valid && m_ready`); wraps modulo 2^CNT_WIDTH.

## Operation
- **State:**
  - `occ` (0..2): captured words held in the buffer.
  - `inflight` (0/1): registered copy of last cycle's `fifo_r_en`.
  - 2-entry circular buffer with head/tail pointers (1 bit each).
- **pop:** `pop = m_valid && m_ready`.
- **Issue rule (combinational):** `fifo_r_en = en && !fifo_empty && (occ + inflight - pop) < 2`. Evaluate in at least 3-bit arithmetic so the subtraction never underflows.
  - `fifo_r_en` is never high while `fifo_empty` is high.
- **Capture:** when `inflight == 1`, write `fifo_data_out` at `tail` on the clock edge and advance `tail`.
- **Output:** `m_valid = (occ != 0)`; `m_data` = entry at `head`. On `pop`, advance `head`.
- **Occupancy update:** `occ_next = occ + inflight - pop`. Simultaneous capture and pop leaves `occ` unchanged.
- **Invariant:** `occ + inflight <= 2` at all times. Buffer overflow is impossible by construction; any violation is a design error and must be asserted in the bench.
- **Ordering:** strict FIFO order is preserved; no word is dropped or duplicated.
- **Stream rules:**
  - Once `m_valid` is high, it stays high and `m_data` stays stable until `pop`.
  - `m_valid` never depends combinationally on `m_ready`.
- **Counter:** `rd_count` increments by 1 on each `pop` and wraps from 2^CNT_WIDTH-1 to 0.
- **Enable:** deasserting `en` only stops new issues. In-flight words are still captured, and buffered words drain normally.

## Timing
- **Reset values:** with `rst_n` low, the following are forced immediately, independent of `clk`:
  - `fifo_r_en` = 0 (combinationally, via `occ`/`inflight` and a reset gate);
  - `m_valid` = 0, `m_data` = 0, `rd_count` = 0;
  - `occ` = 0, `inflight` = 0, pointers = 0, buffer contents = 0.
- **Reset mid-operation:** any buffered or in-flight word is discarded and never presented after release. The first `fifo_r_en` may assert in the first cycle after `rst_n` rises.
- **Latency:** `fifo_r_en` high in cycle N, then `inflight` = 1 in N+1, capture at the end of N+1, `m_valid` high in N+2. First-word latency from `fifo_empty` falling (with `en = 1`) is 2 cycles to `m_valid`.
- **Throughput:** with `m_ready` held high and the FIFO non-empty, `fifo_r_en` and `m_valid` are both high every cycle (1 word/cycle).
- **Backpressure:** with `m_ready` low, at most 2 reads are outstanding in total. Exactly 2 words are pulled before `fifo_r_en` stops.
- **Release after stall:** when `m_ready` rises with `occ = 2`, the pop in that same cycle re-enables `fifo_r_en` (2 + 0 − 1 < 2). No bubble is added beyond the inherent 2-cycle refill.

## Test plan
1. **Reset:** assert `rst_n` low asynchronously mid-cycle → `m_valid`, `fifo_r_en`, `m_data`, `rd_count` all 0 before the next edge.
2. **Single word:** write 0xA5 into the FIFO, `en = 1`, `m_ready = 1` → `fifo_r_en` pulses for exactly 1 cycle; 2 cycles later `m_valid = 1` with `m_data = 0xA5` for 1 cycle; `rd_count = 1`; no further `fifo_r_en` while the FIFO is empty.
3. **Streaming:** FIFO filled with 0x00..0x07, `m_ready = 1` → `fifo_r_en` high 8 consecutive cycles; `m_valid` high 8 consecutive cycles carrying 0x00..0x07 in order; `rd_count = 8`; `fifo_empty` never coincides with `fifo_r_en`.
4. **Backpressure:** FIFO holds 0x10..0x17, `m_ready = 0` → exactly 2 `fifo_r_en` pulses, FIFO left with 6 words, `m_data` held at 0x10. Raise `m_ready` → 0x10..0x17 delivered in order with no loss or duplicate.
5. **Random ready/enable:** toggle `m_ready` and `en` randomly over 200 words → scoreboard matches FIFO order; `occ + inflight <= 2` always; `rd_count` equals the scoreboard count. Repeat with `CNT_WIDTH = 4` to verify wrap from 15 to 0.
6. **Reset mid-stream:** pull `rst_n` low while `occ = 1` and `inflight = 1` → outputs 0 at once; after release, refill the FIFO with 0x55 → the only word presented is 0x55.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Drains a synchronous FIFO (registered data_out, one-cycle read latency)
// into a 2-entry skid buffer and presents the words on a valid/ready stream.
// Reads are only issued when the buffer is guaranteed to have room for the
// word once it arrives, so occupancy plus in-flight reads never exceeds 2.

module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  // Captured words currently held in the buffer (0..2).
  logic [1:0]            r_occ;
  // High in the cycle after a read strobe: fifo_data_out carries a new word.
  logic                  r_inflight;
  logic                  r_head;
  logic                  r_tail;
  logic [DATA_WIDTH-1:0] r_buf [2];
  logic [CNT_WIDTH-1:0]  r_count;

  logic                  w_pop;
  logic [2:0]            w_level;

  // Issue decision: the level after this cycle's capture and pop must leave
  // room for one more word; reset gates the strobe off immediately.
  always_comb begin
    w_pop     = (r_occ != 2'd0) && m_ready;
    w_level   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    fifo_r_en = rst_n && en && !fifo_empty && (w_level < 3'd2);
  end

  assign m_valid  = (r_occ != 2'd0);
  assign m_data   = r_buf[r_head];
  assign rd_count = r_count;

  // Occupancy, in-flight flag, pointers and the transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_count    <= '0;
    end else begin
      r_occ      <= w_level[1:0];
      r_inflight <= fifo_r_en;
      if (r_inflight) begin
        r_tail <= ~r_tail;
      end
      if (w_pop) begin
        r_head  <= ~r_head;
        r_count <= r_count + CNT_WIDTH'(1);
      end
    end
  end

  // Buffer storage: the word returned by last cycle's read lands at tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_buf[i] <= '0;
      end
    end else if (r_inflight) begin
      r_buf[r_tail] <= fifo_data_out;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO model feeds two readers
// (16-bit and 4-bit counters) and a per-cycle model predicts their outputs.

module tb_fifo_stream_reader;

  logic        clock = 1'b0;
  logic        rstN = 1'b1;
  logic        enable = 1'b0;
  logic        mReady = 1'b0;
  logic        fifoEmpty;
  logic [7:0]  fifoDataOut = 8'h00;
  logic        fifoREn, mValid, fifoREn4, mValid4;
  logic [7:0]  mData, mData4;
  logic [15:0] rdCount;
  logic [3:0]  rdCount4;

  logic [7:0]  fifoMem [0:1023];
  int          wrCnt = 0;
  int          rdCnt = 0;
  logic        rdPending = 1'b0;

  logic [7:0]  expQ [$];
  int          expT [$];
  int          expCount = 0;
  int          cycleNo = 0;
  int          nChecks = 0;
  int          nFails = 0;

  always #5 clock = ~clock;

  assign fifoEmpty = (wrCnt == rdCnt);

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clock), .rst_n(rstN), .en(enable), .fifo_empty(fifoEmpty),
    .fifo_data_out(fifoDataOut), .fifo_r_en(fifoREn), .m_valid(mValid),
    .m_ready(mReady), .m_data(mData), .rd_count(rdCount)
  );

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk(clock), .rst_n(rstN), .en(enable), .fifo_empty(fifoEmpty),
    .fifo_data_out(fifoDataOut), .fifo_r_en(fifoREn4), .m_valid(mValid4),
    .m_ready(mReady), .m_data(mData4), .rd_count(rdCount4)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic en);
    mReady = ready;
    enable = en;
  endtask

  task automatic pushWord(input logic [7:0] d);
    fifoMem[wrCnt] = d;
    wrCnt = wrCnt + 1;
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Behavioural FIFO: registered data_out, one word per read strobe.
  always @(posedge clock) begin
    if (rdPending) begin
      fifoDataOut <= fifoMem[rdCnt];
      rdCnt <= rdCnt + 1;
    end
  end

  // Per-cycle model: every word read from the FIFO becomes visible two cycles
  // later and leaves in read order; at most two words are ever outstanding.
  always @(negedge clock) begin : monitor
    logic expValid, expRen, pop;
    int   outstanding;
    cycleNo++;
    if (!rstN) begin
      checkOutput("rst_m_valid", 32'(mValid), 32'd0);
      checkOutput("rst_r_en", 32'(fifoREn), 32'd0);
      checkOutput("rst_m_data", 32'(mData), 32'd0);
      checkOutput("rst_rd_count", 32'(rdCount), 32'd0);
      checkOutput("rst_rd_count_c4", 32'(rdCount4), 32'd0);
      expQ.delete();
      expT.delete();
      expCount = 0;
      rdPending = 1'b0;
    end else begin
      outstanding = expQ.size();
      expValid = 1'b0;
      if (outstanding > 0) begin
        expValid = (expT[0] <= cycleNo - 2);
      end
      checkOutput("m_valid", 32'(mValid), 32'(expValid));
      checkOutput("m_valid_c4", 32'(mValid4), 32'(expValid));
      if (expValid) begin
        checkOutput("m_data_order", 32'(mData), 32'(expQ[0]));
        checkOutput("m_data_order_c4", 32'(mData4), 32'(expQ[0]));
      end
      checkOutput("rd_count", 32'(rdCount), 32'(expCount[15:0]));
      checkOutput("rd_count_wrap_c4", 32'(rdCount4), 32'(expCount[3:0]));
      pop = expValid && mReady;
      expRen = enable && !fifoEmpty && ((outstanding - int'(pop)) < 2);
      checkOutput("fifo_r_en", 32'(fifoREn), 32'(expRen));
      checkOutput("fifo_r_en_c4", 32'(fifoREn4), 32'(expRen));
      checkOutput("occ_plus_inflight_le2", 32'(outstanding <= 2), 32'd1);
      if (pop) begin
        void'(expQ.pop_front());
        void'(expT.pop_front());
        expCount++;
      end
      if (fifoREn && !fifoEmpty) begin
        expQ.push_back(fifoMem[rdCnt]);
        expT.push_back(cycleNo);
      end
      rdPending = fifoREn && !fifoEmpty;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    logic [7:0] dHist [12];
    logic       rHist [12];
    logic       vHist [12];
    int         renCount, pushed, vCount;
    logic       drained;

    // Reset state
    #1 rstN = 1'b0;
    #1;
    checkOutput("reset_m_valid", 32'(mValid), 32'd0);
    checkOutput("reset_r_en", 32'(fifoREn), 32'd0);
    checkOutput("reset_m_data", 32'(mData), 32'd0);
    checkOutput("reset_rd_count", 32'(rdCount), 32'd0);
    repeat (3) tick();
    rstN = 1'b1;
    applyStimulus(1'b1, 1'b1);
    repeat (2) tick();

    // Single word
    $display("[TB] single word");
    pushWord(8'hA5);
    #1;
    checkOutput("single_r_en_c0", 32'(fifoREn), 32'd1);
    tick();
    checkOutput("single_r_en_c1", 32'(fifoREn), 32'd0);
    checkOutput("single_m_valid_c1", 32'(mValid), 32'd0);
    tick();
    checkOutput("single_m_valid_c2", 32'(mValid), 32'd1);
    checkOutput("single_m_data_c2", 32'(mData), 32'hA5);
    tick();
    checkOutput("single_m_valid_c3", 32'(mValid), 32'd0);
    checkOutput("single_rd_count", 32'(rdCount), 32'd1);
    checkOutput("single_r_en_c3", 32'(fifoREn), 32'd0);

    // Streaming 0x00..0x07
    $display("[TB] streaming");
    for (int i = 0; i < 8; i++) pushWord(8'(i));
    #1;
    for (int i = 0; i < 12; i++) begin
      rHist[i] = fifoREn;
      vHist[i] = mValid;
      dHist[i] = mData;
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("stream_r_en_%0d", i), 32'(rHist[i]), 32'(i < 8));
      checkOutput($sformatf("stream_valid_%0d", i), 32'(vHist[i]), 32'(i >= 2 && i < 10));
      if (i >= 2 && i < 10) begin
        checkOutput($sformatf("stream_data_%0d", i), 32'(dHist[i]), 32'(i - 2));
      end
    end
    checkOutput("stream_rd_count", 32'(rdCount), 32'd9);

    // Backpressure 0x10..0x17
    $display("[TB] backpressure");
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) pushWord(8'(8'h10 + i));
    #1;
    renCount = 0;
    for (int i = 0; i < 6; i++) begin
      if (fifoREn) renCount++;
      tick();
    end
    checkOutput("bp_r_en_pulses", 32'(renCount), 32'd2);
    checkOutput("bp_fifo_left", 32'(wrCnt - rdCnt), 32'd6);
    checkOutput("bp_m_valid", 32'(mValid), 32'd1);
    checkOutput("bp_m_data_held", 32'(mData), 32'h10);
    checkOutput("bp_r_en_stopped", 32'(fifoREn), 32'd0);
    applyStimulus(1'b1, 1'b1);
    #1;
    checkOutput("bp_release_r_en", 32'(fifoREn), 32'd1);
    repeat (12) tick();
    checkOutput("bp_rd_count", 32'(rdCount), 32'd17);
    checkOutput("bp_fifo_empty", 32'(fifoEmpty), 32'd1);
    checkOutput("bp_m_valid_end", 32'(mValid), 32'd0);

    // Random ready/enable over 200 words
    $display("[TB] random ready/enable");
    pushed = 0;
    for (int c = 0; c < 3000 && pushed < 200; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      if ((wrCnt - rdCnt) < 3 && $urandom_range(0, 1) == 1) begin
        pushWord(8'($urandom));
        pushed++;
      end
      tick();
    end
    checkOutput("rand_pushed", 32'(pushed), 32'd200);
    applyStimulus(1'b1, 1'b1);
    drained = 1'b0;
    for (int c = 0; c < 50 && !drained; c++) begin
      tick();
      drained = fifoEmpty && !mValid && (expQ.size() == 0);
    end
    checkOutput("rand_drained", 32'(drained), 32'd1);
    checkOutput("rand_rd_count", 32'(rdCount), 32'd217);
    checkOutput("rand_rd_count_c4", 32'(rdCount4), 32'd9);

    // Reset mid-stream with occ = 1 and inflight = 1
    $display("[TB] reset mid-stream");
    applyStimulus(1'b0, 1'b1);
    pushWord(8'h60);
    pushWord(8'h61);
    tick();
    tick();
    checkOutput("mid_m_valid_before", 32'(mValid), 32'd1);
    checkOutput("mid_m_data_before", 32'(mData), 32'h60);
    rstN = 1'b0;
    #1;
    checkOutput("mid_rst_m_valid", 32'(mValid), 32'd0);
    checkOutput("mid_rst_m_data", 32'(mData), 32'd0);
    checkOutput("mid_rst_rd_count", 32'(rdCount), 32'd0);
    checkOutput("mid_rst_r_en", 32'(fifoREn), 32'd0);
    tick();
    tick();
    rstN = 1'b1;
    applyStimulus(1'b1, 1'b1);
    pushWord(8'h55);
    vCount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mValid) begin
        vCount++;
        checkOutput("mid_only_0x55", 32'(mData), 32'h55);
      end
    end
    checkOutput("mid_words_presented", 32'(vCount), 32'd1);
    checkOutput("mid_rd_count", 32'(rdCount), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
